// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU and its issue/writeback stage.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_MAX = 3'd4;
  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic              use_acc;
  } alu_req_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; SUB reports borrow on carry_out, illegal opcodes give all zeros.
module alu
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  input  logic [OP_W-1:0] opcode,
  output logic [W-1:0]    result,
  output logic            carry_out,
  output logic            zero
);

  logic [W:0] w_sum;

  // Opcode decode into a W+1 bit sum carrying the carry/borrow in its MSB.
  always_comb begin
    w_sum = '0;
    case (opcode)
      OP_ADD:  w_sum = {1'b0, A} + {1'b0, B};
      OP_SUB:  w_sum = {1'b0, A} - {1'b0, B};
      OP_AND:  w_sum = {1'b0, A & B};
      OP_OR:   w_sum = {1'b0, A | B};
      OP_XOR:  w_sum = {1'b0, A ^ B};
      default: w_sum = '0;
    endcase
  end

  assign result    = w_sum[W-1:0];
  assign carry_out = w_sum[W];
  assign zero      = (w_sum[W-1:0] == '0);

endmodule

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO for pending ALU requests; head read from storage at the registered read pointer.
module alu_issue_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointer and storage update; flush collapses both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/writeback stage around the combinational alu: request FIFO, accumulator,
// registered output slot with valid/ready, and a wrapping issue counter.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_use_acc,
  input  logic             flush,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err,
  output logic [CNT_W-1:0] issued_cnt
);

  alu_req_t    w_req;
  alu_req_t    w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_issue;
  logic        w_legal;
  slot_state_t r_state;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  assign w_req = '{a: in_a, b: in_b, op: in_op, use_acc: in_use_acc};

  alu_issue_fifo #(
    .DW    ($bits(alu_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (in_valid),
    .i_data  (w_req),
    .i_pop   (w_issue),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready = !w_full;
  assign w_issue  = !w_empty && ((r_state == SLOT_EMPTY) || out_ready) && !flush;
  assign w_legal  = op_is_legal(w_head.op);

  // ALU operands come straight from the FIFO head; quiet zeros when nothing is queued.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (!w_empty) begin
      alu_a  = w_head.use_acc ? r_acc : w_head.a;
      alu_b  = w_head.b;
      alu_op = w_head.op;
    end else begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = '0;
    end
  end

  // Output slot FSM, result capture, accumulator and issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SLOT_EMPTY;
      r_acc    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_state  <= SLOT_EMPTY;
      r_acc    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        SLOT_EMPTY: r_state <= w_issue ? SLOT_FULL : SLOT_EMPTY;
        SLOT_FULL:  r_state <= (w_issue || !out_ready) ? SLOT_FULL : SLOT_EMPTY;
        default:    r_state <= SLOT_EMPTY;
      endcase
      if (w_issue) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_legal) begin
          r_result <= alu_result;
          r_carry  <= alu_carry;
          r_zero   <= alu_zero;
          r_err    <= 1'b0;
          r_acc    <= alu_result;
        end else begin
          r_result <= '0;
          r_carry  <= 1'b0;
          r_zero   <= 1'b0;
          r_err    <= 1'b1;
        end
      end
    end
  end

  assign out_valid  = (r_state == SLOT_FULL);
  assign out_result = r_result;
  assign out_carry  = r_carry;
  assign out_zero   = r_zero;
  assign out_err    = r_err;
  assign issued_cnt = r_cnt;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit paired with alu.
module tb_alu_issue_unit;
  import alu_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_a = 8'd0;
  logic [W-1:0] in_b = 8'd0;
  logic [2:0] in_op = 3'd0;
  logic in_use_acc = 1'b0;
  logic flush = 1'b0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic alu_carry, alu_zero;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic out_carry, out_zero, out_err;
  logic [CNT_W-1:0] issued_cnt;

  int n_checks = 0;
  int n_fail = 0;
  logic [10:0] sb_q[$];
  logic [7:0] m_acc = 8'd0;

  alu_issue_unit #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
    .flush(flush), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_err(out_err),
    .issued_cnt(issued_cnt)
  );

  alu #(.W(W)) u_alu (
    .A(alu_a), .B(alu_b), .opcode(alu_op),
    .result(alu_result), .carry_out(alu_carry), .zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Reference model: expected {err, zero, carry, result} in acceptance order.
  task automatic sb_push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic use_acc);
    logic [8:0] s;
    logic [7:0] ea;
    logic err;
    ea = use_acc ? m_acc : a;
    err = 1'b0;
    case (op)
      3'd0: s = {1'b0, ea} + {1'b0, b};
      3'd1: s = {1'b0, ea} - {1'b0, b};
      3'd2: s = {1'b0, ea & b};
      3'd3: s = {1'b0, ea | b};
      3'd4: s = {1'b0, ea ^ b};
      default: begin s = 9'd0; err = 1'b1; end
    endcase
    if (!err) m_acc = s[7:0];
    sb_q.push_back({err, (!err && s[7:0] == 8'd0), s[8], s[7:0]});
  endtask

  // Offer one op (caller sits just after a rising edge); returns just after the accepting edge.
  task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic use_acc);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_use_acc = use_acc;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_push(a, b, op, use_acc);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL push_timeout: accepted=%0d required=1", done); end
  endtask

  task automatic drain_wait();
    for (int c = 0; c < 60 && sb_q.size() != 0; c++) @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL drain_timeout: pending=%0d required=0", sb_q.size()); end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got=%b exp=0", out_valid); end
    n_checks++; if ({out_result, out_carry, out_zero, out_err} !== 11'd0) begin
      n_fail++; $display("FAIL rst_out_data: got=%h exp=0", {out_result, out_carry, out_zero, out_err}); end
    n_checks++; if ({alu_a, alu_b, alu_op} !== 19'd0) begin
      n_fail++; $display("FAIL rst_alu_drive: got=%h exp=0", {alu_a, alu_b, alu_op}); end
    n_checks++; if (issued_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_issued_cnt: got=%0d exp=0", issued_cnt); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency(input logic [15:0] exp_cnt);
    out_ready = 1'b1;
    push_op(8'h0F, 8'h01, 3'd0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid: got=%b exp=0", out_valid); end
    n_checks++; if ({alu_a, alu_b, alu_op} !== {8'h0F, 8'h01, 3'd0}) begin
      n_fail++; $display("FAIL lat_alu_drive: got=%h exp=%h", {alu_a, alu_b, alu_op}, {8'h0F, 8'h01, 3'd0}); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got=%b exp=1", out_valid); end
    n_checks++; if ({out_result, out_carry, out_zero, out_err} !== {8'h10, 3'b000}) begin
      n_fail++; $display("FAIL lat_result: got=%h exp=%h", {out_result, out_carry, out_zero, out_err}, {8'h10, 3'b000}); end
    n_checks++; if (issued_cnt !== exp_cnt) begin n_fail++; $display("FAIL lat_cnt: got=%0d exp=%0d", issued_cnt, exp_cnt); end
    drain_wait();
  endtask

  task automatic test_chain();
    out_ready = 1'b1;
    push_op(8'hFF, 8'h01, 3'd0, 1'b0);
    push_op(8'hAA, 8'h05, 3'd0, 1'b1);
    n_checks++; if ({out_valid, out_result, out_carry, out_zero} !== {1'b1, 8'h00, 2'b11}) begin
      n_fail++; $display("FAIL chain_first: got=%h exp=%h", {out_valid, out_result, out_carry, out_zero}, {1'b1, 8'h00, 2'b11}); end
    @(posedge clk); #1;
    n_checks++; if ({out_valid, out_result, out_carry} !== {1'b1, 8'h05, 1'b0}) begin
      n_fail++; $display("FAIL chain_second: got=%h exp=%h", {out_valid, out_result, out_carry}, {1'b1, 8'h05, 1'b0}); end
    drain_wait();
  endtask

  task automatic test_backpressure();
    int acc_n;
    logic [7:0] held;
    acc_n = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (acc_n < 6);
      in_a = 8'(5 * (acc_n + 1)); in_b = 8'h20; in_op = 3'(acc_n % 5); in_use_acc = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb_push(in_a, in_b, in_op, in_use_acc);
        acc_n++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (acc_n != DEPTH + 1) begin n_fail++; $display("FAIL bp_accepts: got=%0d exp=%0d", acc_n, DEPTH + 1); end
    n_checks++; if ({in_ready, out_valid} !== 2'b01) begin
      n_fail++; $display("FAIL bp_flags: got=%b exp=01", {in_ready, out_valid}); end
    held = out_result;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({out_valid, out_result} !== {1'b1, held}) begin
      n_fail++; $display("FAIL bp_stable: got=%h exp=%h", {out_valid, out_result}, {1'b1, held}); end
    out_ready = 1'b1;
    drain_wait();
  endtask

  task automatic test_illegal();
    logic [15:0] cnt0;
    out_ready = 1'b1;
    cnt0 = issued_cnt;
    push_op(8'h12, 8'h22, 3'd0, 1'b0);
    push_op(8'h77, 8'h11, 3'd5, 1'b0);
    @(posedge clk); #1;
    n_checks++; if ({out_valid, out_err, out_result, out_carry, out_zero} !== {2'b11, 8'h00, 2'b00}) begin
      n_fail++; $display("FAIL illegal_out: got=%h exp=%h", {out_valid, out_err, out_result, out_carry, out_zero}, {2'b11, 8'h00, 2'b00}); end
    push_op(8'h00, 8'h00, 3'd0, 1'b1);
    push_op(8'h3F, 8'h01, 3'd7, 1'b0);
    drain_wait();
    n_checks++; if (issued_cnt !== cnt0 + 16'd4) begin
      n_fail++; $display("FAIL illegal_cnt: got=%0d exp=%0d", issued_cnt, cnt0 + 16'd4); end
  endtask

  task automatic test_flush();
    logic [15:0] cnt0;
    out_ready = 1'b0;
    push_op(8'h21, 8'h10, 3'd0, 1'b0);
    push_op(8'h01, 8'h02, 3'd3, 1'b0);
    push_op(8'h03, 8'h04, 3'd0, 1'b1);
    push_op(8'h05, 8'h06, 3'd4, 1'b0);
    cnt0 = issued_cnt;
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h99; in_b = 8'h01; in_op = 3'd0; in_use_acc = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    m_acc = 8'd0;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_flags: got=%b exp=01", {out_valid, in_ready}); end
    n_checks++; if ({alu_a, alu_b, alu_op} !== 19'd0) begin
      n_fail++; $display("FAIL flush_fifo_empty: got=%h exp=0", {alu_a, alu_b, alu_op}); end
    n_checks++; if (issued_cnt !== cnt0) begin n_fail++; $display("FAIL flush_cnt: got=%0d exp=%0d", issued_cnt, cnt0); end
    push_op(8'hEE, 8'h07, 3'd0, 1'b1);
    drain_wait();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    push_op(8'h11, 8'h22, 3'd0, 1'b0);
    push_op(8'h33, 8'h44, 3'd1, 1'b0);
    push_op(8'h55, 8'h66, 3'd2, 1'b0);
    in_valid = 1'b1; in_a = 8'h77; in_b = 8'h01; in_op = 3'd0;
    #3 rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    sb_q.delete();
    m_acc = 8'd0;
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL arst_flags: got=%b exp=10", {in_ready, out_valid}); end
    n_checks++; if ({out_result, out_carry, out_zero, out_err} !== 11'd0) begin
      n_fail++; $display("FAIL arst_out_data: got=%h exp=0", {out_result, out_carry, out_zero, out_err}); end
    n_checks++; if ({alu_a, alu_b, alu_op, issued_cnt} !== 35'd0) begin
      n_fail++; $display("FAIL arst_alu_cnt: got=%h exp=0", {alu_a, alu_b, alu_op, issued_cnt}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_latency(16'd1);
  endtask

  initial begin
    fork
      forever begin
        logic [10:0] got;
        logic [10:0] exp;
        @(negedge clk);
        if (rst_n && !flush && out_valid && out_ready) begin
          got = {out_err, out_zero, out_carry, out_result};
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++; $display("FAIL out_unexpected: got=%h exp=none", got);
          end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL out_result: got=%h exp=%h", got, exp); end
          end
        end
      end
    join_none
    test_reset();
    test_latency(16'd1);
    test_chain();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
